// File: rtl/pwm_capture.sv
// PWM period/duty capture: measures clocks between rising edges and high time.
// Define PWM_CAPTURE_SYNC_EN to pass pwm_in through a 2-flop synchronizer.
module pwm_capture #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] duty,
  output logic             valid,
  output logic             timeout,
  output logic             level
);

  localparam logic IDLE    = 1'b0;
  localparam logic MEASURE = 1'b1;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic             s;
  logic             s_prev;
  logic             rise;
  logic             state;
  logic [WIDTH-1:0] period_cnt;
  logic [WIDTH-1:0] high_cnt;

`ifdef PWM_CAPTURE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pwm_in};
    end
  end

  assign s = sync_q[1];
`else
  assign s = pwm_in;
`endif

  assign rise = s & ~s_prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      s_prev     <= 1'b0;
      period_cnt <= '0;
      high_cnt   <= '0;
      period     <= '0;
      duty       <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
      level      <= 1'b0;
    end else begin
      s_prev  <= s;
      valid   <= 1'b0;
      timeout <= 1'b0;
      if (!enable) begin
        state      <= IDLE;
        period_cnt <= '0;
        high_cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (rise) begin
              state      <= MEASURE;
              period_cnt <= ONE;
              high_cnt   <= ONE;
            end
          end
          MEASURE: begin
            // a rise wins over saturation so a full-scale period is still reported
            if (rise) begin
              period     <= period_cnt;
              duty       <= high_cnt;
              valid      <= 1'b1;
              period_cnt <= ONE;
              high_cnt   <= ONE;
            end else if (period_cnt == CNT_MAX) begin
              timeout    <= 1'b1;
              level      <= s;
              state      <= IDLE;
            end else begin
              period_cnt <= period_cnt + ONE;
              if (s) begin
                high_cnt <= high_cnt + ONE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
